// File: rtl/xgmii_pkg.sv
// rtl/xgmii_pkg.sv - shared XGMII control characters and packer state encoding
package xgmii_pkg;

  localparam logic [7:0]  XGMII_IDLE      = 8'h07;
  localparam logic [7:0]  XGMII_START     = 8'hFB;
  localparam logic [7:0]  XGMII_TERM      = 8'hFD;
  localparam logic [7:0]  XGMII_ERROR     = 8'hFE;
  localparam logic [63:0] XGMII_IDLE_WORD = {8{XGMII_IDLE}};
  localparam logic [7:0]  XGMII_IDLE_CTRL = 8'hFF;

  typedef enum logic [1:0] {
    IDLE,
    DATA,
    TERM
  } state_t;

endpackage

// File: rtl/xgmii_packer.sv
// rtl/xgmii_packer.sv - packs 1/2/4-byte beats into 64-bit XGMII words; PACKER_ERR_EN maps in_er onto /E/
module xgmii_packer
  import xgmii_pkg::*;
#(
  parameter int IN_BYTES = 1
) (
  input  logic                  xgmii_clk,
  input  logic                  sys_rst,
  input  logic                  in_en,
  input  logic [IN_BYTES-1:0]   in_dv,
  input  logic [8*IN_BYTES-1:0] in_d,
  input  logic [IN_BYTES-1:0]   in_er,
  output logic [63:0]           xgmii_rxd,
  output logic [7:0]            xgmii_rxc,
  output logic                  xgmii_valid
);

  state_t              state, state_nx;
  logic [2:0]          ptr, ptr_nx;
  logic [63:0]         acc_d, acc_d_nx;
  logic [7:0]          acc_c, acc_c_nx;
  logic [63:0]         rxd_nx;
  logic [7:0]          rxc_nx;
  logic                valid_nx;

  logic [63:0]         cur_d, ovf_d;
  logic [7:0]          cur_c, ovf_c;
  logic [7:0]          lane_d [IN_BYTES];
  logic [IN_BYTES-1:0] lane_c;
  logic [3:0]          lane_pos [IN_BYTES];
  logic [IN_BYTES-1:0] err_mask;
  logic                start, take, last;
  logic [2:0]          base;
  logic [3:0]          count, term_pos;

`ifdef PACKER_ERR_EN
  assign err_mask = in_er;
`else
  logic unused_er;
  assign err_mask  = '0;
  assign unused_er = ^in_er;
`endif

  // TERM behaves like IDLE for incoming beats: a start beat may land while the TERM word goes out.
  assign start = in_en && in_dv[0] && (state != DATA);
  assign take  = in_en && (state == DATA);
  assign last  = ~&in_dv;
  assign base  = start ? 3'd0 : ptr;

  for (genvar i = 0; i < IN_BYTES; i++) begin : g_lane
    assign lane_pos[i] = {1'b0, base} + 4'(i);
    if (i == 0) begin : g_first
      assign lane_d[i] = start ? XGMII_START : (err_mask[i] ? XGMII_ERROR : in_d[8*i +: 8]);
      assign lane_c[i] = start | err_mask[i];
    end else begin : g_rest
      assign lane_d[i] = err_mask[i] ? XGMII_ERROR : in_d[8*i +: 8];
      assign lane_c[i] = err_mask[i];
    end
  end

  always_comb begin
    count = '0;
    for (int i = 0; i < IN_BYTES; i++) count = count + {3'd0, in_dv[i]};
  end

  assign term_pos = {1'b0, base} + count;

  // Lanes past 7 spill into ovf, which seeds the next accumulator word.
  always_comb begin
    cur_d = start ? XGMII_IDLE_WORD : acc_d;
    cur_c = start ? XGMII_IDLE_CTRL : acc_c;
    ovf_d = XGMII_IDLE_WORD;
    ovf_c = XGMII_IDLE_CTRL;
    for (int i = 0; i < IN_BYTES; i++) begin
      if (in_dv[i]) begin
        if (lane_pos[i][3]) begin
          ovf_d[{lane_pos[i][2:0], 3'b000} +: 8] = lane_d[i];
          ovf_c[lane_pos[i][2:0]]                = lane_c[i];
        end else begin
          cur_d[{lane_pos[i][2:0], 3'b000} +: 8] = lane_d[i];
          cur_c[lane_pos[i][2:0]]                = lane_c[i];
        end
      end
    end
    if (take && last) begin
      if (term_pos[3]) begin
        ovf_d[{term_pos[2:0], 3'b000} +: 8] = XGMII_TERM;
        ovf_c[term_pos[2:0]]                = 1'b1;
      end else begin
        cur_d[{term_pos[2:0], 3'b000} +: 8] = XGMII_TERM;
        cur_c[term_pos[2:0]]                = 1'b1;
      end
    end
  end

  always_comb begin
    state_nx = state;
    ptr_nx   = ptr;
    acc_d_nx = acc_d;
    acc_c_nx = acc_c;
    rxd_nx   = xgmii_rxd;
    rxc_nx   = xgmii_rxc;
    valid_nx = 1'b0;

    if (state == TERM) begin
      rxd_nx   = acc_d;
      rxc_nx   = acc_c;
      valid_nx = 1'b1;
      state_nx = IDLE;
      ptr_nx   = '0;
      acc_d_nx = XGMII_IDLE_WORD;
      acc_c_nx = XGMII_IDLE_CTRL;
    end

    if (start) begin
      state_nx = DATA;
      ptr_nx   = term_pos[2:0];
      acc_d_nx = cur_d;
      acc_c_nx = cur_c;
    end else if (take) begin
      if (last) begin
        rxd_nx   = cur_d;
        rxc_nx   = cur_c;
        valid_nx = 1'b1;
        ptr_nx   = '0;
        acc_d_nx = ovf_d;
        acc_c_nx = ovf_c;
        state_nx = term_pos[3] ? TERM : IDLE;
      end else begin
        ptr_nx = term_pos[2:0];
        if (term_pos[3]) begin
          rxd_nx   = cur_d;
          rxc_nx   = cur_c;
          valid_nx = 1'b1;
          acc_d_nx = ovf_d;
          acc_c_nx = ovf_c;
        end else begin
          acc_d_nx = cur_d;
          acc_c_nx = cur_c;
        end
      end
    end
  end

  always_ff @(posedge xgmii_clk) begin
    if (sys_rst) begin
      state       <= IDLE;
      ptr         <= '0;
      acc_d       <= XGMII_IDLE_WORD;
      acc_c       <= XGMII_IDLE_CTRL;
      xgmii_rxd   <= XGMII_IDLE_WORD;
      xgmii_rxc   <= XGMII_IDLE_CTRL;
      xgmii_valid <= 1'b0;
    end else begin
      state       <= state_nx;
      ptr         <= ptr_nx;
      acc_d       <= acc_d_nx;
      acc_c       <= acc_c_nx;
      xgmii_rxd   <= rxd_nx;
      xgmii_rxc   <= rxc_nx;
      xgmii_valid <= valid_nx;
    end
  end

endmodule

// File: doc/xgmii_packer.md
XGMII_PACKER -- requirements
Module: xgmii_packer

Interface
REQ-001 SHALL have parameter IN_BYTES, default 1: bytes per input beat; legal values 1, 2, 4.
REQ-002 SHALL have port xgmii_clk, input, 1: the single clock for all logic.
REQ-003 SHALL have port sys_rst, input, 1: synchronous, active-high reset.
REQ-004 SHALL have port in_en, input, 1: input beat qualifier; a beat is taken only when in_en=1.
REQ-005 SHALL have port in_dv, input, IN_BYTES: per-byte data valid; set lanes are contiguous from lane 0.
REQ-006 SHALL have port in_d, input, 8*IN_BYTES: byte lanes, with lane 0 in bits [7:0] as the earliest byte.
REQ-007 SHALL have port in_er, input, IN_BYTES: per-byte error flag; used only when PACKER_ERR_EN is defined.
REQ-008 SHALL have port xgmii_rxd, output, 64: packed XGMII data, with lane 0 in bits [7:0].
REQ-009 SHALL have port xgmii_rxc, output, 8: per-lane control flag (1 = control character).
REQ-010 SHALL have port xgmii_valid, output, 1: one-cycle strobe marking a complete 64-bit word.

Function
REQ-011 SHALL implement the states IDLE, DATA and TERM.
REQ-012 SHALL treat a beat with in_dv[0]=1 taken in IDLE as the frame start:
- lane pointer forced to 0
- byte 0 replaced by /S/ (0xFB, rxc=1) regardless of its value
- go to DATA.
REQ-013 SHALL, in DATA, place each valid byte at pointer+i with rxc=0, then advance the pointer by popcount(in_dv) modulo 8.
REQ-014 SHALL register the word one cycle after the beat that fills lane 7, with xgmii_valid=1 for one cycle.
REQ-015 SHALL end the frame on any taken beat with in_dv not all-ones, including in_dv=0.
REQ-016 SHALL, on frame end with terminate lane < 8, write /T/ (0xFD, rxc=1) in the lane after the last data byte, fill the remaining lanes with /I/ (0x07, rxc=1), emit that word next cycle and go to IDLE.
REQ-017 SHALL, on frame end with the last data byte in lane 7, go to TERM and emit FD followed by 7x07 (rxc=0xFF) next cycle; TERM then returns to IDLE.
REQ-018 SHALL, when a new-frame start beat arrives in the same cycle the TERM word is emitted, accept the start beat into an empty accumulator at lane 0 without losing either the start or the TERM word.
REQ-019 SHALL ignore in_d, in_dv and in_er whenever in_en=0; the state and pointer hold.
REQ-020 SHALL ignore taken beats with in_dv[0]=0 in IDLE; no output results.
REQ-021 SHALL emit at most one word per cycle; IN_BYTES ≤ 4 guarantees no overrun.

Reset
REQ-022 SHALL, while sys_rst=1, set:
- state=IDLE, pointer=0
- xgmii_rxd=0x0707070707070707, xgmii_rxc=0xFF, xgmii_valid=0.
REQ-023 SHALL, on reset asserted mid-frame, discard the partial word with no /T/ emitted; the first beat after reset with in_dv[0]=1 starts a fresh frame.

Configuration
REQ-024 SHALL, with macro PACKER_ERR_EN defined, replace any valid byte with in_er=1 in DATA by /E/ (0xFE, rxc=1); framing is unchanged.
REQ-025 SHALL, without PACKER_ERR_EN, leave in_er unconnected internally and pass data bytes unaltered.

Structure
REQ-026 SHALL take the following from shared package xgmii_pkg:
- constants XGMII_IDLE=8'h07, XGMII_START=8'hFB, XGMII_TERM=8'hFD, XGMII_ERROR=8'hFE, XGMII_IDLE_WORD
- the state enum.
REQ-027 SHALL be a single flat module with no sub-module; lane insertion is a generate loop over IN_BYTES.

Verification
REQ-028 SHALL pass this case: IN_BYTES=1, 8-byte frame 55 55 55 55 55 55 55 D5 then dv=0 -> word 1 rxd=0xD5555555555555FB, rxc=0x01; word 2 = FD+7x07, rxc=0xFF.
REQ-029 SHALL pass this case: IN_BYTES=1, 11-byte frame ending AA BB CC -> second word lanes 0-2 = AA BB CC (rxc=0), lane 3 = FD, lanes 4-7 = 07, rxc=0xF8.
REQ-030 SHALL pass this case: IN_BYTES=4, final beat in_dv=0011 at pointer 4 -> lanes 4,5 data, lane 6 = FD, lane 7 = 07, rxc=0xC0.
REQ-031 SHALL pass this case: IN_BYTES=2, in_en toggling 1/0 every cycle through a 16-byte frame -> output identical to the gap-free run; only xgmii_valid timing stretches.
REQ-032 SHALL pass this case: sys_rst pulsed after 5 data bytes, then a new frame -> no FD word emitted; the next valid word starts with FB in lane 0.
REQ-033 SHALL pass this case: PACKER_ERR_EN defined, in_er=1 on the 3rd data byte -> lane 2 = FE with rxc bit 2 set; other lanes unchanged.
